// File: rtl/m_wbgpio.sv
// Wishbone-classic GPIO peripheral: output register, synchronised inputs with
// sticky edge capture, per-bit interrupt enables and a registered level interrupt.
// One wait state: ACK_O and DAT_O are registered off the sampled request.
module m_wbgpio #(
  parameter int unsigned       NOUT     = 4,
  parameter int unsigned       NIN      = 1,
  parameter logic [NOUT-1:0]   OUTRESET = '0,
  parameter int unsigned       EDGEMODE = 0
) (
  input  logic            CLK_I,
  input  logic            RST_N_I,
  input  logic            CYC_I,
  input  logic            STB_I,
  input  logic            WE_I,
  input  logic [1:0]      ADR_I,
  input  logic [3:0]      SEL_I,
  input  logic [31:0]     DAT_I,
  output logic [31:0]     DAT_O,
  output logic            ACK_O,
  input  logic [NIN-1:0]  gpi,
  output logic [NOUT-1:0] gpo,
  output logic            irq
);

  localparam logic [1:0] AdrOut   = 2'd0;
  localparam logic [1:0] AdrIn    = 2'd1;
  localparam logic [1:0] AdrEdge  = 2'd2;
  localparam logic [1:0] AdrIrqen = 2'd3;

  logic            ack_q;
  logic [31:0]     dat_q, dat_d;
  logic [NOUT-1:0] out_q, out_d;
  logic [NIN-1:0]  irqen_q, irqen_d;
  logic [NIN-1:0]  flag_q, flag_d;
  logic [NIN-1:0]  s1_q, s2_q, s3_q;
  logic [1:0]      prime_q, prime_d;
  logic            irq_q, irq_d;

  logic            req, wr_req, rd_req;
  logic [31:0]     lane_mask;
  logic [31:0]     out_ext, in_ext, flag_ext, irqen_ext;
  logic [31:0]     out_wr, irqen_wr, clr_ext, rdata;
  logic [NIN-1:0]  rise, fall, evt, clr;
  logic            armed;
  logic            unused_bits;

  // Bus request decode; a request is never taken while the previous ack is high.
  always_comb begin
    req       = CYC_I & STB_I & ~ack_q;
    wr_req    = req & WE_I;
    rd_req    = req & ~WE_I;
    lane_mask = {{8{SEL_I[3]}}, {8{SEL_I[2]}}, {8{SEL_I[1]}}, {8{SEL_I[0]}}};
  end

  // Zero-extend stored registers to bus width; bits above NOUT/NIN read 0.
  always_comb begin
    out_ext                = '0;
    in_ext                 = '0;
    flag_ext               = '0;
    irqen_ext              = '0;
    out_ext[NOUT-1:0]      = out_q;
    in_ext[NIN-1:0]        = s2_q;
    flag_ext[NIN-1:0]      = flag_q;
    irqen_ext[NIN-1:0]     = irqen_q;
  end

  // Byte-lane merged write values and the write-1-to-clear mask.
  always_comb begin
    out_wr      = (out_ext & ~lane_mask) | (DAT_I & lane_mask);
    irqen_wr    = (irqen_ext & ~lane_mask) | (DAT_I & lane_mask);
    clr_ext     = (wr_req && ADR_I == AdrEdge) ? (DAT_I & lane_mask) : '0;
    clr         = clr_ext[NIN-1:0];
    unused_bits = ^{out_wr, irqen_wr, clr_ext};
  end

  // Edge detection on the synchronised pin, gated until the prime counter saturates.
  always_comb begin
    rise    = s2_q & ~s3_q;
    fall    = ~s2_q & s3_q;
    unique case (EDGEMODE)
      0:       evt = rise;
      1:       evt = fall;
      default: evt = rise | fall;
    endcase
    armed   = (prime_q == 2'd3);
    prime_d = armed ? prime_q : prime_q + 2'd1;
  end

  // Register next-state: writes commit on the acknowledging edge; set beats clear.
  always_comb begin
    out_d   = (wr_req && ADR_I == AdrOut) ? out_wr[NOUT-1:0] : out_q;
    irqen_d = (wr_req && ADR_I == AdrIrqen) ? irqen_wr[NIN-1:0] : irqen_q;
    flag_d  = (flag_q & ~clr) | (armed ? evt : '0);
    irq_d   = |(flag_q & irqen_q);
  end

  // Read mux; data only presented alongside the ack, zero otherwise.
  always_comb begin
    rdata = '0;
    unique case (ADR_I)
      AdrOut:   rdata = out_ext;
      AdrIn:    rdata = in_ext;
      AdrEdge:  rdata = flag_ext;
      AdrIrqen: rdata = irqen_ext;
      default:  rdata = '0;
    endcase
    dat_d = rd_req ? rdata : '0;
  end

  // Bus response registers.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= dat_d;
    end
  end

  // Software-visible state and interrupt.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      out_q   <= OUTRESET;
      irqen_q <= '0;
      flag_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      irqen_q <= irqen_d;
      flag_q  <= flag_d;
      irq_q   <= irq_d;
    end
  end

  // Input synchroniser, history flop and edge-arming counter.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      prime_q <= 2'd0;
    end else begin
      s1_q    <= gpi;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      prime_q <= prime_d;
    end
  end

  assign ACK_O = ack_q;
  assign DAT_O = dat_q;
  assign gpo   = out_q;
  assign irq   = irq_q;

endmodule
